alu_issue_unit: RTL and testbench



---
 rtl/alu_issue_unit_if.sv | 25 ++
 rtl/alu_issue_unit.sv | 153 +++++++++++++++
 tb/tb_alu_issue_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_unit_if.sv
// Command and result valid/ready channels of alu_issue_unit.
// The issue unit sits on the slave side; the producer/consumer environment is the master.
interface alu_issue_unit_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_sel;

  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_out;
  logic       res_carry;
  logic       res_zero;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, res_ready,
    input  cmd_ready, res_valid, res_out, res_carry, res_zero
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, res_ready,
    output cmd_ready, res_valid, res_out, res_carry, res_zero
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Buffers ALU commands in a FIFO, drives the external combinational ALU from
// registers, captures its outputs and hands each result off over valid/ready.
module alu_issue_unit #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_issue_unit_if.slave          bus,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic [1:0]               alu_sel,
  input  logic [3:0]               alu_out,
  input  logic                     alu_carry,
  input  logic                     alu_zero,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               res_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] sel;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          cmd_in;
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  state_t        state;
  state_t        state_nxt;
  logic          push;
  logic          pop;
  logic          capture;
  logic          handshake;
  logic          fifo_empty;
  logic          res_valid_q;
  logic [3:0]    res_out_q;
  logic          res_carry_q;
  logic          res_zero_q;

  // cmd_ready depends on the registered level only, so no input reaches it combinationally.
  assign bus.cmd_ready = (fifo_level != FULL_LEVEL);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign fifo_empty    = (fifo_level == '0);
  assign handshake     = res_valid_q && bus.res_ready;
  assign cmd_in        = {bus.cmd_a, bus.cmd_b, bus.cmd_sel};
  assign head          = mem[rd_ptr];

  assign bus.res_valid = res_valid_q;
  assign bus.res_out   = res_out_q;
  assign bus.res_carry = res_carry_q;
  assign bus.res_zero  = res_zero_q;

  // NOTE: the storage array carries no reset; only pointers and level define
  // which entries are live, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  // NOTE: every sequential block uses non-blocking assignments so all registers
  // update together from pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        capture   = 1'b1;
        state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (handshake) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = ST_DRIVE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      res_out_q   <= '0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_count   <= '0;
    end else begin
      if (pop) begin
        alu_a   <= head.a;
        alu_b   <= head.b;
        alu_sel <= head.sel;
      end
      if (capture) begin
        res_out_q   <= alu_out;
        res_carry_q <= alu_carry;
        res_zero_q  <= alu_zero;
        res_valid_q <= 1'b1;
      end else if (handshake) begin
        res_valid_q <= 1'b0;
      end
      if (handshake) res_count <= res_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Randomized and directed bench for alu_issue_unit with a behavioural ALU and
// a queue-based scoreboard of expected results in acceptance order.
module tb_alu_issue_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  alu_a, alu_b;
  logic [1:0]  alu_sel;
  logic [3:0]  alu_out;
  logic        alu_carry, alu_zero;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [7:0]  res_count;

  alu_issue_unit_if bus ();

  alu_issue_unit #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .fifo_level (fifo_level),
    .res_count  (res_count)
  );

  always #5 clk = ~clk;

  // Combinational ALU the unit drives.
  logic [4:0] alu_sum;
  assign alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_out   = (alu_sel == 2'b00) ? (alu_a & alu_b) :
                     (alu_sel == 2'b01) ? (alu_a | alu_b) :
                     (alu_sel == 2'b10) ? (alu_a ^ alu_b) : alu_sum[3:0];
  assign alu_carry = (alu_sel == 2'b11) && alu_sum[4];
  assign alu_zero  = (alu_out == 4'd0);

  int          total = 0;
  int          passed = 0;
  int          cyc = 0;
  int unsigned model_count = 0;
  logic [5:0]  exp_q [$];
  logic [5:0]  got_q [$];
  int          hs_cyc [$];
  logic        hold_pending = 1'b0;
  logic [5:0]  held = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Expected {out[3:0], carry, zero} from the operation rules.
  function automatic logic [5:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
    int r;
    int c;
    c = 0;
    case (sel)
      2'd0: r = int'(a & b);
      2'd1: r = int'(a | b);
      2'd2: r = int'(a ^ b);
      default: begin
        r = (int'(a) + int'(b)) % 16;
        c = ((int'(a) + int'(b)) > 15) ? 1 : 0;
      end
    endcase
    return {4'(r), (c != 0), (r == 0)};
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] s, input logic rr, output logic acc);
    logic [5:0] got;
    if (hold_pending) begin
      check("hold_valid", bus.res_valid, 1);
      check("hold_data", {bus.res_out, bus.res_carry, bus.res_zero}, held);
    end
    bus.cmd_valid = v;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = s;
    bus.res_ready = rr;
    #1;
    got = {bus.res_out, bus.res_carry, bus.res_zero};
    if (bus.res_valid && bus.res_ready) begin
      got_q.push_back(got);
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_result", got, 6'h3f ^ got);
      else check("result", got, exp_q.pop_front());
      model_count++;
    end
    acc = bus.cmd_valid && bus.cmd_ready;
    if (acc) exp_q.push_back(ref_alu(a, b, s));
    hold_pending = bus.res_valid && !bus.res_ready;
    held = got;
    @(negedge clk);
    cyc++;
    check("res_count", res_count, model_count % 256);
  endtask

  task automatic idle(input logic rr);
    logic acc;
    cycle(1'b0, 4'd0, 4'd0, 2'd0, rr, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.res_valid) && n < 100) begin
      idle(1'b1);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    check("drain_no_valid", bus.res_valid, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    check({tag, "_fifo_level"}, fifo_level, 0);
    check({tag, "_res_count"}, res_count, 0);
    check({tag, "_alu_ops"}, {alu_a, alu_b, alu_sel}, 0);
    check({tag, "_res_data"}, {bus.res_out, bus.res_carry, bus.res_zero}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   n_acc;
    int   idx;
    int   base;
    int   n;

    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_sel   = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("after_reset");

    // Latency: accept at edge N, res_valid after edge N+2.
    cycle(1'b1, 4'h3, 4'h1, 2'b11, 1'b0, acc);
    check("lat_accept", acc, 1);
    check("lat_n0_valid", bus.res_valid, 0);
    idle(1'b0);
    check("lat_n1_valid", bus.res_valid, 0);
    idle(1'b0);
    check("lat_n2_valid", bus.res_valid, 1);
    check("lat_data", {bus.res_out, bus.res_carry, bus.res_zero}, 6'b010000);
    idle(1'b1);
    check("lat_count", res_count, 1);

    // Back-to-back commands with the consumer always ready.
    got_q.delete();
    hs_cyc.delete();
    cycle(1'b1, 4'h4, 4'h2, 2'b00, 1'b1, acc);
    cycle(1'b1, 4'hC, 4'hA, 2'b01, 1'b1, acc);
    cycle(1'b1, 4'hC, 4'hA, 2'b10, 1'b1, acc);
    drain();
    check("b2b_count", got_q.size(), 3);
    if (got_q.size() >= 3) begin
      check("b2b_and", got_q[0], 6'b000001);
      check("b2b_or", got_q[1], 6'b111000);
      check("b2b_xor", got_q[2], 6'b011000);
      check("b2b_gap1", hs_cyc[1] - hs_cyc[0], 2);
      check("b2b_gap2", hs_cyc[2] - hs_cyc[1], 2);
    end

    // ADD overflow: result wraps to zero with carry.
    got_q.delete();
    cycle(1'b1, 4'hF, 4'h1, 2'b11, 1'b1, acc);
    drain();
    check("ovf_count", got_q.size(), 1);
    if (got_q.size() >= 1) check("ovf_data", got_q[0], 6'b000011);

    // Backpressure: offer DEPTH+2 commands while the consumer stalls.
    n_acc = 0;
    idx   = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(idx < DEPTH + 2, 4'(idx * 3), 4'(idx + 7), 2'(idx), 1'b0, acc);
      if (acc) begin
        n_acc++;
        idx++;
      end
    end
    check("bp_accepted", n_acc, DEPTH + 1);
    check("bp_level", fifo_level, DEPTH);
    check("bp_cmd_ready", bus.cmd_ready, 0);
    check("bp_res_valid", bus.res_valid, 1);
    check("bp_head", {bus.res_out, bus.res_carry, bus.res_zero}, ref_alu(4'd0, 4'd7, 2'd0));
    base = got_q.size();
    drain();
    check("bp_released", got_q.size() - base, DEPTH + 1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), acc);
    end
    drain();

    // Asynchronous reset mid-HOLD with entries queued.
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i + 1), 4'(9 - i), 2'(i), 1'b0, acc);
    idle(1'b0);
    check("pre_rst_valid", bus.res_valid, 1);
    check("pre_rst_level", fifo_level, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    exp_q.delete();
    model_count  = 0;
    hold_pending = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) idle(1'b1);
    check("post_rst_no_stale", bus.res_valid, 0);
    check("post_rst_level", fifo_level, 0);

    // 256 handshakes wrap res_count back to zero.
    n = 0;
    while (model_count < 256 && n < 3000) begin
      cycle((model_count + exp_q.size()) < 256, 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'b1, acc);
      n++;
    end
    drain();
    check("wrap_handshakes", model_count, 256);
    check("wrap_count", res_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
